// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC array feeder: default geometry,
// operand type, feeder state encoding and stream length.
package systolic_pkg;

  localparam int DEFAULT_N  = 4;
  localparam int DEFAULT_DW = 8;

  typedef logic signed [DEFAULT_DW-1:0] operand_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DONE
  } feeder_state_e;

  // Skewed injection takes 2N-1 cycles; N-1 more cycles of zeros let the last
  // operands reach PE(N-1,N-1).
  function automatic int stream_len(input int n);
    return 3 * n - 2;
  endfunction

  localparam int STREAM_LEN = stream_len(DEFAULT_N);

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Host-side bus of the skew feeder: buffer writes and start in, array edge
// operands and pass status out.
interface systolic_skew_feeder_if
  import systolic_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int DW = DEFAULT_DW
);

  localparam int IW = $clog2(N);

  logic              i_wr_en;
  logic              i_wr_sel;
  logic [IW-1:0]     i_wr_idx;
  logic [N*DW-1:0]   i_wr_data;
  logic              i_start;

  logic              o_array_rst_n;
  logic [N*DW-1:0]   o_a;
  logic [N*DW-1:0]   o_b;
  logic              o_busy;
  logic              o_done;

  // Host that loads matrices and launches passes.
  modport master (
    output i_wr_en, i_wr_sel, i_wr_idx, i_wr_data, i_start,
    input  o_array_rst_n, o_a, o_b, o_busy, o_done
  );

  // The feeder itself.
  modport slave (
    input  i_wr_en, i_wr_sel, i_wr_idx, i_wr_data, i_start,
    output o_array_rst_n, o_a, o_b, o_busy, o_done
  );

endinterface

// File: rtl/feeder_buffer.sv
// NxN operand register file: a whole row vector is written at once, and every
// lane reads one element of its own row per cycle.
module feeder_buffer #(
  parameter int N  = 4,
  parameter int DW = 8,
  localparam int IW = $clog2(N)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [IW-1:0]         i_wr_idx,
  input  logic [N*DW-1:0]       i_wr_data,
  input  logic [N-1:0][IW-1:0]  i_rd_k,
  output logic [N-1:0][DW-1:0]  o_rd_data
);

  logic [N-1:0][N-1:0][DW-1:0] mem;

  // Row write; contents cleared on reset.
  // NOTE: this storage is reset on purpose -- a pass launched right after reset
  // must stream zeros, not power-up garbage, so it is built from resettable flops.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mem <= '0;
    end else if (i_wr_en) begin
      mem[i_wr_idx] <= i_wr_data;
    end
  end

  // Lane r reads element i_rd_k[r] of row r.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      o_rd_data[r] = mem[r][i_rd_k[r]];
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Feeds one A x B multiply into an NxN systolic MAC array: clears the array,
// streams A rows west and B columns north with diagonal skew and zero padding,
// then pulses done once every PE holds its final dot product.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int DW = DEFAULT_DW
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  systolic_skew_feeder_if.slave bus
);

  localparam int IW  = $clog2(N);
  localparam int CW  = $clog2(3 * N);
  localparam int LEN = stream_len(N);

  feeder_state_e state, next_state;
  logic [CW-1:0] t, next_t;

  logic                 wr_ok;
  logic [N-1:0][IW-1:0] lane_k;
  logic [N-1:0]         lane_ok;
  logic [N-1:0][DW-1:0] a_rd, b_rd;

  logic [N-1:0][DW-1:0] a_d, b_d;
  logic                 busy_d, done_d, arst_n_d;

  // Buffers only take writes while no pass is reading them.
  assign wr_ok = (state == IDLE) || (state == DONE);

  feeder_buffer #(.N(N), .DW(DW)) u_buf_a (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (bus.i_wr_en && wr_ok && !bus.i_wr_sel),
    .i_wr_idx  (bus.i_wr_idx),
    .i_wr_data (bus.i_wr_data),
    .i_rd_k    (lane_k),
    .o_rd_data (a_rd)
  );

  // B is stored column-major, so lane j reading entry [j][k] yields B[k][j].
  feeder_buffer #(.N(N), .DW(DW)) u_buf_b (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (bus.i_wr_en && wr_ok && bus.i_wr_sel),
    .i_wr_idx  (bus.i_wr_idx),
    .i_wr_data (bus.i_wr_data),
    .i_rd_k    (lane_k),
    .o_rd_data (b_rd)
  );

  // State and stream-step register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      state <= next_state;
      t     <= next_t;
    end
  end

  // Next-state and stream-step sequencing.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    next_state = state;
    next_t     = t;
    case (state)
      IDLE: begin
        next_t = '0;
        if (bus.i_start) next_state = CLEAR;
      end
      CLEAR: begin
        next_state = STREAM;
        next_t     = '0;
      end
      STREAM: begin
        if (t == CW'(LEN - 1)) begin
          next_state = DONE;
          next_t     = '0;
        end else begin
          next_t = t + CW'(1);
        end
      end
      DONE: begin
        next_t     = '0;
        next_state = bus.i_start ? CLEAR : IDLE;
      end
      default: begin
        next_state = IDLE;
        next_t     = '0;
      end
    endcase
  end

  // Skew: lane l carries element k = t - l while that lies in 0..N-1.
  always_comb begin
    for (int l = 0; l < N; l++) begin
      lane_k[l]  = '0;
      lane_ok[l] = 1'b0;
      if ((next_t >= CW'(l)) && ((next_t - CW'(l)) <= CW'(N - 1))) begin
        lane_ok[l] = 1'b1;
        lane_k[l]  = IW'(next_t - CW'(l));
      end
    end
  end

  // Output values for the upcoming state, registered below.
  always_comb begin
    a_d      = '0;
    b_d      = '0;
    busy_d   = (next_state == CLEAR) || (next_state == STREAM);
    done_d   = (next_state == DONE);
    arst_n_d = (next_state != CLEAR);
    if (next_state == STREAM) begin
      for (int l = 0; l < N; l++) begin
        if (lane_ok[l]) begin
          a_d[l] = a_rd[l];
          b_d[l] = b_rd[l];
        end
      end
    end
  end

  // Registered outputs; reset holds the array in reset as well.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bus.o_a           <= '0;
      bus.o_b           <= '0;
      bus.o_busy        <= 1'b0;
      bus.o_done        <= 1'b0;
      bus.o_array_rst_n <= 1'b0;
    end else begin
      bus.o_a           <= a_d;
      bus.o_b           <= b_d;
      bus.o_busy        <= busy_d;
      bus.o_done        <= done_d;
      bus.o_array_rst_n <= arst_n_d;
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: per-cycle edge operands come from a
// scoreboard queue filled at each start, and a behavioural NxN MAC array driven
// by the feeder outputs is compared against A*B at the done cycle.
module tb_systolic_skew_feeder;
  import systolic_pkg::*;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int IW   = $clog2(N);
  localparam int LAST = 3 * N;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.N(N), .DW(DW)) bus ();

  systolic_skew_feeder #(.N(N), .DW(DW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic            arst;
    logic            busy;
    logic            done;
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] b;
  } exp_t;

  exp_t     exp_q[$];
  operand_t a_m[N][N];
  operand_t b_m[N][N];
  int       n_checks = 0;
  int       n_fail   = 0;

  // ---------------- behavioural systolic array ----------------
  operand_t          pe_a[N][N];
  operand_t          pe_b[N][N];
  logic signed [15:0] pe_acc[N][N];

  function automatic operand_t lane_of(input logic [N*DW-1:0] v, input int l);
    return v[l*DW +: DW];
  endfunction

  function automatic operand_t west_in(input int i, input int j);
    return (j == 0) ? lane_of(bus.o_a, i) : pe_a[i][j-1];
  endfunction

  function automatic operand_t north_in(input int i, input int j);
    return (i == 0) ? lane_of(bus.o_b, j) : pe_b[i-1][j];
  endfunction

  function automatic logic signed [15:0] mul16(input operand_t x, input operand_t y);
    int p;
    p = int'(x) * int'(y);
    return p[15:0];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!bus.o_array_rst_n) begin
          pe_a[i][j]   <= '0;
          pe_b[i][j]   <= '0;
          pe_acc[i][j] <= '0;
        end else begin
          pe_a[i][j]   <= west_in(i, j);
          pe_b[i][j]   <= north_in(i, j);
          pe_acc[i][j] <= pe_acc[i][j] + mul16(west_in(i, j), north_in(i, j));
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] exp_out(input int i, input int j);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += int'(a_m[i][k]) * int'(b_m[k][j]);
    return s[15:0];
  endfunction

  // Queue the expected outputs for cycles 1..3N of a pass on current matrices.
  task automatic push_expected();
    for (int c = 1; c <= LAST; c++) begin
      exp_t e;
      e.arst = (c != 1);
      e.busy = (c < LAST);
      e.done = (c == LAST);
      e.a    = '0;
      e.b    = '0;
      if (c >= 2 && c <= LAST - 1) begin
        for (int l = 0; l < N; l++) begin
          int k;
          k = (c - 2) - l;
          if (k >= 0 && k < N) begin
            e.a[l*DW +: DW] = a_m[l][k];
            e.b[l*DW +: DW] = b_m[k][l];
          end
        end
      end
      exp_q.push_back(e);
    end
  endtask

  // Advance one cycle and compare outputs against the scoreboard (or idle).
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e.arst = 1'b1;
      e.busy = 1'b0;
      e.done = 1'b0;
      e.a    = '0;
      e.b    = '0;
    end
    check("array_rst_n", 64'(bus.o_array_rst_n), 64'(e.arst));
    check("busy",        64'(bus.o_busy),        64'(e.busy));
    check("done",        64'(bus.o_done),        64'(e.done));
    check("lanes_a",     64'(bus.o_a),           64'(e.a));
    check("lanes_b",     64'(bus.o_b),           64'(e.b));
  endtask

  task automatic drive_row(input logic sel, input int idx);
    logic [N*DW-1:0] d;
    for (int k = 0; k < N; k++) d[k*DW +: DW] = sel ? b_m[k][idx] : a_m[idx][k];
    bus.i_wr_en   = 1'b1;
    bus.i_wr_sel  = sel;
    bus.i_wr_idx  = IW'(idx);
    bus.i_wr_data = d;
  endtask

  task automatic write_row(input logic sel, input int idx);
    drive_row(sel, idx);
    tick();
    bus.i_wr_en = 1'b0;
  endtask

  task automatic load_a();
    for (int i = 0; i < N; i++) write_row(1'b0, i);
  endtask

  task automatic load_b();
    for (int j = 0; j < N; j++) write_row(1'b1, j);
  endtask

  task automatic begin_pass();
    push_expected();
    bus.i_start = 1'b1;
  endtask

  // mode 0: plain pass; 1: ignored write + start at t=3; 2: reset at t=5.
  task automatic run_pass(input int mode);
    for (int c = 1; c <= LAST; c++) begin
      tick();
      bus.i_start = 1'b0;
      bus.i_wr_en = 1'b0;
      if (mode == 1 && c == 5) begin
        bus.i_wr_en   = 1'b1;
        bus.i_wr_sel  = 1'b0;
        bus.i_wr_idx  = '0;
        bus.i_wr_data = '1;
        bus.i_start   = 1'b1;
      end
      if (mode == 2 && c == 7) begin
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("abort_busy",        64'(bus.o_busy),        64'(0));
        check("abort_done",        64'(bus.o_done),        64'(0));
        check("abort_a",           64'(bus.o_a),           64'(0));
        check("abort_b",           64'(bus.o_b),           64'(0));
        check("abort_array_rst_n", 64'(bus.o_array_rst_n), 64'(0));
        rst_n = 1'b1;
        for (int i = 0; i < N; i++)
          for (int k = 0; k < N; k++) begin
            a_m[i][k] = '0;
            b_m[i][k] = '0;
          end
        return;
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check("pe_out", 64'(pe_acc[i][j]), 64'(exp_out(i, j)));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n         = 1'b0;
    bus.i_wr_en   = 1'b0;
    bus.i_wr_sel  = 1'b0;
    bus.i_wr_idx  = '0;
    bus.i_wr_data = '0;
    bus.i_start   = 1'b0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_m[i][k] = '0;
        b_m[i][k] = '0;
      end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a",           64'(bus.o_a),           64'(0));
    check("rst_b",           64'(bus.o_b),           64'(0));
    check("rst_busy",        64'(bus.o_busy),        64'(0));
    check("rst_done",        64'(bus.o_done),        64'(0));
    check("rst_array_rst_n", 64'(bus.o_array_rst_n), 64'(0));
    rst_n = 1'b1;
    tick();

    // Identity A, B[k][j] = 10k + j: results 10i + j.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_m[i][k] = (i == k) ? 8'sd1 : 8'sd0;
        b_m[i][k] = operand_t'(10 * i + k);
      end
    load_a();
    load_b();
    begin_pass();
    run_pass(0);
    tick();

    // Skew pattern A[i][k] = 16i + k + 1.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) a_m[i][k] = operand_t'(16 * i + k + 1);
    load_a();
    begin_pass();
    run_pass(0);
    tick();

    // Signed extremes: every operand -128, accumulators wrap to 0.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_m[i][k] = -8'sd128;
        b_m[i][k] = -8'sd128;
      end
    load_a();
    load_b();
    begin_pass();
    run_pass(0);
    tick();

    // Write + start during STREAM are both ignored.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_m[i][k] = operand_t'(16 * i + k + 1);
        b_m[i][k] = operand_t'(3 * i - 5 * k);
      end
    load_a();
    load_b();
    begin_pass();
    run_pass(1);
    tick();
    tick();

    // Buffers unchanged; then restart from the DONE cycle.
    begin_pass();
    run_pass(0);
    begin_pass();
    run_pass(0);
    tick();

    // Reset at t = 5 aborts the pass and clears the buffers.
    begin_pass();
    run_pass(2);
    tick();

    // Fresh A only: B buffer must read back as zeros.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) a_m[i][k] = (i == k) ? 8'sd2 : 8'sd0;
    load_a();
    begin_pass();
    run_pass(0);
    tick();

    // Load B; the last column write shares its cycle with start.
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) b_m[k][j] = operand_t'(k - 2 * j + 1);
    for (int j = 0; j < N - 1; j++) write_row(1'b1, j);
    drive_row(1'b1, N - 1);
    begin_pass();
    run_pass(0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
